// File: rtl/seven_seg_scan_if.sv
// ============================================================================
// seven_seg_scan_if : control, data and display bundle for the scan controller
// Rev 1.0
// ============================================================================
`default_nettype none

interface seven_seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    blank_lz;
  logic [3:0]              digit_hex;
  logic [NUM_DIGITS-1:0]   an;
  logic                    dp;
  logic                    frame_tick;
  logic                    pending;

  modport master (
    output en, load, value, dp_in, blank_lz,
    input  digit_hex, an, dp, frame_tick, pending
  );

  modport slave (
    input  en, load, value, dp_in, blank_lz,
    output digit_hex, an, dp, frame_tick, pending
  );
endinterface

`default_nettype wire

// File: rtl/seven_seg_scan.sv
// ============================================================================
// seven_seg_scan : double-buffered time-multiplexed 7-seg digit scanner
// Rev 1.0
// ============================================================================
`default_nettype none

module seven_seg_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  wire              clk,
  input  wire              rst_n,
  seven_seg_scan_if.slave  bus
);

  localparam int c_CNT_W = $clog2(REFRESH_DIV);
  localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int c_VAL_W = 4 * NUM_DIGITS;

  logic [c_CNT_W-1:0]    r_cnt;
  logic [c_IDX_W-1:0]    r_idx;
  logic [c_VAL_W-1:0]    r_disp;
  logic [c_VAL_W-1:0]    r_pend;
  logic                  r_pending;
  logic [3:0]            r_digit_hex;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_dp;
  logic                  r_frame_tick;

  logic                  w_cnt_last;
  logic                  w_idx_last;
  logic                  w_frame_end;
  logic [NUM_DIGITS-1:0] w_upper_zero;
  logic [3:0]            w_nibble;
  logic                  w_dp_sel;
  logic                  w_uz_sel;
  logic                  w_blank;
  logic                  w_lit;

  assign w_cnt_last  = (r_cnt == c_CNT_W'(REFRESH_DIV - 1));
  assign w_idx_last  = (r_idx == c_IDX_W'(NUM_DIGITS - 1));
  assign w_frame_end = w_cnt_last && w_idx_last;

  // w_upper_zero[i]: every nibble from digit i up to the top digit is zero
  always_comb begin
    w_upper_zero = '0;
    w_upper_zero[NUM_DIGITS-1] = (r_disp[c_VAL_W-1 -: 4] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      w_upper_zero[i] = w_upper_zero[i+1] && (r_disp[4*i +: 4] == 4'h0);
    end
  end

  always_comb begin
    w_nibble = 4'h0;
    w_dp_sel = 1'b0;
    w_uz_sel = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == c_IDX_W'(i)) begin
        w_nibble = r_disp[4*i +: 4];
        w_dp_sel = bus.dp_in[i];
        w_uz_sel = w_upper_zero[i];
      end
    end
  end

  assign w_blank = bus.blank_lz && (r_idx != '0) && w_uz_sel;
  assign w_lit   = bus.en && !w_blank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_disp       <= '0;
      r_pend       <= '0;
      r_pending    <= 1'b0;
      r_digit_hex  <= 4'h0;
      r_an         <= '1;
      r_dp         <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_cnt <= w_cnt_last ? '0 : r_cnt + c_CNT_W'(1);
      if (w_cnt_last) begin
        r_idx <= w_idx_last ? '0 : r_idx + c_IDX_W'(1);
      end

      // A load landing on the frame-end cycle bypasses the pending buffer
      if (bus.load && w_frame_end) begin
        r_disp    <= bus.value;
        r_pending <= 1'b0;
      end else if (bus.load) begin
        r_pend    <= bus.value;
        r_pending <= 1'b1;
      end else if (w_frame_end && r_pending) begin
        r_disp    <= r_pend;
        r_pending <= 1'b0;
      end

      r_digit_hex  <= w_nibble;
      r_an         <= w_lit ? ~(NUM_DIGITS'(1) << r_idx) : '1;
      r_dp         <= w_lit ? ~w_dp_sel : 1'b1;
      r_frame_tick <= w_frame_end;
    end
  end

  assign bus.digit_hex  = r_digit_hex;
  assign bus.an         = r_an;
  assign bus.dp         = r_dp;
  assign bus.frame_tick = r_frame_tick;
  assign bus.pending    = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
// ============================================================================
// tb_seven_seg_scan : directed checks of scanning, buffering, blanking, reset
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_seven_seg_scan;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  logic [3:0] c_an_slot [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  seven_seg_scan_if #(.NUM_DIGITS(4)) bus ();

  seven_seg_scan #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.frame_tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit exp_ft;
    int s;
    bus.en = 1'b1; bus.load = 1'b0; bus.value = '0; bus.dp_in = '0; bus.blank_lz = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.an !== 4'b1111) $display("FAIL reset_an: got %b expected 1111", bus.an); else n_pass++;
    n_checks++; if (bus.dp !== 1'b1) $display("FAIL reset_dp: got %b expected 1", bus.dp); else n_pass++;
    n_checks++; if (bus.digit_hex !== 4'h0) $display("FAIL reset_hex: got %h expected 0", bus.digit_hex); else n_pass++;
    n_checks++; if (bus.frame_tick !== 1'b0) $display("FAIL reset_tick: got %b expected 0", bus.frame_tick); else n_pass++;
    n_checks++; if (bus.pending !== 1'b0) $display("FAIL reset_pending: got %b expected 0", bus.pending); else n_pass++;
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      s = ((k - 1) % 16) / 4;
      exp_ft = (k == 16) || (k == 32);
      n_checks++; if (bus.an !== c_an_slot[s]) $display("FAIL scan_an k=%0d: got %b expected %b", k, bus.an, c_an_slot[s]); else n_pass++;
      n_checks++; if (bus.digit_hex !== 4'h0) $display("FAIL scan_hex k=%0d: got %h expected 0", k, bus.digit_hex); else n_pass++;
      n_checks++; if (bus.frame_tick !== exp_ft) $display("FAIL scan_tick k=%0d: got %b expected %b", k, bus.frame_tick, exp_ft); else n_pass++;
    end
  endtask

  task automatic test_load();
    logic [3:0] exp_hex [4] = '{4'hF, 4'h3, 4'hA, 4'h1};
    bit ok;
    repeat (5) tick();
    bus.value = 16'h1A3F; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    n_checks++; if (bus.pending !== 1'b1) $display("FAIL load_pending: got %b expected 1", bus.pending); else n_pass++;
    repeat (8) tick();
    n_checks++; if (bus.pending !== 1'b1) $display("FAIL load_pending_hold: got %b expected 1", bus.pending); else n_pass++;
    n_checks++; if (bus.digit_hex !== 4'h0) $display("FAIL load_no_tear: got %h expected 0", bus.digit_hex); else n_pass++;
    wait_frame(ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL load_frame_timeout: got %b expected 1", ok); else n_pass++;
    n_checks++; if (bus.pending !== 1'b0) $display("FAIL load_pending_clear: got %b expected 0", bus.pending); else n_pass++;
    for (int k = 0; k < 16; k++) begin
      tick();
      n_checks++; if (bus.an !== c_an_slot[k/4]) $display("FAIL load_an k=%0d: got %b expected %b", k, bus.an, c_an_slot[k/4]); else n_pass++;
      n_checks++; if (bus.digit_hex !== exp_hex[k/4]) $display("FAIL load_hex k=%0d: got %h expected %h", k, bus.digit_hex, exp_hex[k/4]); else n_pass++;
    end
    n_checks++; if (bus.frame_tick !== 1'b1) $display("FAIL load_frame_align: got %b expected 1", bus.frame_tick); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    repeat (2) tick();
    bus.value = 16'h1111; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    repeat (3) tick();
    bus.value = 16'h2222; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    n_checks++; if (bus.pending !== 1'b1) $display("FAIL b2b_pending: got %b expected 1", bus.pending); else n_pass++;
    wait_frame(ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL b2b_frame_timeout: got %b expected 1", ok); else n_pass++;
    for (int k = 0; k < 16; k++) begin
      tick();
      n_checks++; if (bus.digit_hex !== 4'h2) $display("FAIL b2b_hex k=%0d: got %h expected 2", k, bus.digit_hex); else n_pass++;
    end
  endtask

  task automatic test_load_at_frame_end();
    logic [3:0] exp_hex [4] = '{4'h2, 4'h4, 4'h0, 4'h0};
    logic       exp_dp  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bus.dp_in = 4'b0110;
    repeat (15) tick();
    bus.value = 16'h0042; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    n_checks++; if (bus.frame_tick !== 1'b1) $display("FAIL fe_align: got %b expected 1", bus.frame_tick); else n_pass++;
    n_checks++; if (bus.pending !== 1'b0) $display("FAIL fe_pending: got %b expected 0", bus.pending); else n_pass++;
    for (int k = 0; k < 16; k++) begin
      tick();
      n_checks++; if (bus.digit_hex !== exp_hex[k/4]) $display("FAIL fe_hex k=%0d: got %h expected %h", k, bus.digit_hex, exp_hex[k/4]); else n_pass++;
      n_checks++; if (bus.an !== c_an_slot[k/4]) $display("FAIL fe_an k=%0d: got %b expected %b", k, bus.an, c_an_slot[k/4]); else n_pass++;
      n_checks++; if (bus.dp !== exp_dp[k/4]) $display("FAIL fe_dp k=%0d: got %b expected %b", k, bus.dp, exp_dp[k/4]); else n_pass++;
      n_checks++; if (bus.pending !== 1'b0) $display("FAIL fe_pending_k k=%0d: got %b expected 0", k, bus.pending); else n_pass++;
    end
  endtask

  task automatic test_blank();
    logic [3:0] exp_an;
    logic [3:0] exp_hex;
    bus.dp_in = 4'b0000;
    bus.blank_lz = 1'b1;
    repeat (15) tick();
    bus.value = 16'h0007; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_an  = (k <= 4) ? 4'b1110 : 4'b1111;
      exp_hex = (k <= 4) ? 4'h7 : 4'h0;
      n_checks++; if (bus.an !== exp_an) $display("FAIL lz7_an k=%0d: got %b expected %b", k, bus.an, exp_an); else n_pass++;
      n_checks++; if (bus.digit_hex !== exp_hex) $display("FAIL lz7_hex k=%0d: got %h expected %h", k, bus.digit_hex, exp_hex); else n_pass++;
      if (k == 15) begin
        bus.value = 16'h0000; bus.load = 1'b1;
      end
      if (k == 16) bus.load = 1'b0;
    end
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_an = (k <= 4) ? 4'b1110 : 4'b1111;
      n_checks++; if (bus.an !== exp_an) $display("FAIL lz0_an k=%0d: got %b expected %b", k, bus.an, exp_an); else n_pass++;
      n_checks++; if (bus.digit_hex !== 4'h0) $display("FAIL lz0_hex k=%0d: got %h expected 0", k, bus.digit_hex); else n_pass++;
    end
    bus.blank_lz = 1'b0;
  endtask

  task automatic test_enable();
    bit exp_ft;
    bus.en = 1'b0;
    bus.dp_in = 4'b1111;
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_ft = (k == 16);
      n_checks++; if (bus.an !== 4'b1111) $display("FAIL en_an k=%0d: got %b expected 1111", k, bus.an); else n_pass++;
      n_checks++; if (bus.dp !== 1'b1) $display("FAIL en_dp k=%0d: got %b expected 1", k, bus.dp); else n_pass++;
      n_checks++; if (bus.frame_tick !== exp_ft) $display("FAIL en_tick k=%0d: got %b expected %b", k, bus.frame_tick, exp_ft); else n_pass++;
    end
    bus.en = 1'b1;
  endtask

  task automatic test_midreset();
    bus.dp_in = 4'b0001;
    bus.value = 16'h5555; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    repeat (2) tick();
    n_checks++; if (bus.an !== 4'b1110) $display("FAIL mr_pre_an: got %b expected 1110", bus.an); else n_pass++;
    n_checks++; if (bus.pending !== 1'b1) $display("FAIL mr_pre_pending: got %b expected 1", bus.pending); else n_pass++;
    n_checks++; if (bus.dp !== 1'b0) $display("FAIL mr_pre_dp: got %b expected 0", bus.dp); else n_pass++;
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.an !== 4'b1111) $display("FAIL mr_an: got %b expected 1111", bus.an); else n_pass++;
    n_checks++; if (bus.pending !== 1'b0) $display("FAIL mr_pending: got %b expected 0", bus.pending); else n_pass++;
    n_checks++; if (bus.dp !== 1'b1) $display("FAIL mr_dp: got %b expected 1", bus.dp); else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      n_checks++; if (bus.digit_hex !== 4'h0) $display("FAIL mr_hex k=%0d: got %h expected 0", k, bus.digit_hex); else n_pass++;
      n_checks++; if (bus.an !== c_an_slot[(k-1)/4]) $display("FAIL mr_an_k k=%0d: got %b expected %b", k, bus.an, c_an_slot[(k-1)/4]); else n_pass++;
    end
    n_checks++; if (bus.frame_tick !== 1'b1) $display("FAIL mr_tick: got %b expected 1", bus.frame_tick); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_load_at_frame_end();
    test_blank();
    test_enable();
    test_midreset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
